// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD frame driver: ASCII codes, frame FSM states
// and the BCD-to-LCD character decode.
package lcd_pkg;

   localparam logic [7:0] LCD_ZERO  = 8'h30;
   localparam logic [7:0] LCD_ERROR = 8'h3A;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } state_t;

   function automatic logic [7:0] bcd_to_lcd(input logic [3:0] digit);
      if (digit <= 4'd9)
         return LCD_ZERO + {4'd0, digit};
      else
         return LCD_ERROR;
   endfunction

endpackage

// File: rtl/alarm_sounder.sv
// Alarm sounder: fires on a rising edge of the time match, runs for a fixed
// number of cycles, and is silenced by the button.
module alarm_sounder #(
   parameter  int DW           = 16,
   parameter  int ALARM_CYCLES = 1000,
   localparam int CNT_W        = $clog2(ALARM_CYCLES + 1)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [DW-1:0] alarm_time,
   input  logic [DW-1:0] current_time,
   input  logic          alarm_enable,
   input  logic          alarm_button,
   output logic          sound_alarm
);

   logic             w_match;
   logic             w_rise;
   logic             r_match_q;
   logic             r_sound;
   logic [CNT_W-1:0] r_timer;

   assign w_match = alarm_enable && (current_time == alarm_time);
   assign w_rise  = w_match && !r_match_q;

   // The button has priority over a coincident match edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_match_q <= 1'b0;
         r_sound   <= 1'b0;
         r_timer   <= '0;
      end else begin
         r_match_q <= w_match;
         if (alarm_button) begin
            r_sound <= 1'b0;
            r_timer <= '0;
         end else if (w_rise) begin
            r_sound <= 1'b1;
            r_timer <= CNT_W'(ALARM_CYCLES);
         end else if (r_sound) begin
            if (r_timer == CNT_W'(1)) begin
               r_sound <= 1'b0;
               r_timer <= '0;
            end else begin
               r_timer <= r_timer - CNT_W'(1);
            end
         end
      end
   end

   assign sound_alarm = r_sound;

endmodule

// File: rtl/lcd_frame_driver.sv
// Snapshots one selected multi-digit BCD source per refresh and streams it to
// the LCD interface as ASCII characters, most significant digit first.
module lcd_frame_driver
   import lcd_pkg::*;
#(
   parameter  int NUM_DIGITS   = 4,
   parameter  int ALARM_CYCLES = 1000,
   localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] alarm_time,
   input  logic [4*NUM_DIGITS-1:0] current_time,
   input  logic [4*NUM_DIGITS-1:0] key,
   input  logic                    show_new_time,
   input  logic                    show_alarm,
   input  logic                    alarm_enable,
   input  logic                    alarm_button,
   input  logic                    refresh,
   output logic [7:0]              lcd_char,
   output logic                    lcd_valid,
   input  logic                    lcd_ready,
   output logic [IDX_W-1:0]        lcd_index,
   output logic                    frame_done,
   output logic                    sound_alarm
);

   localparam int               DW       = 4 * NUM_DIGITS;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   state_t           r_state;
   state_t           w_state_next;
   logic [DW-1:0]    r_shadow;
   logic [7:0]       r_char;
   logic             r_valid;
   logic [IDX_W-1:0] r_index;
   logic             r_done;
   logic             r_pending;

   logic [DW-1:0]    w_src;
   logic [DW-1:0]    w_shadow_shl;
   logic             w_xfer;
   logic             w_last;
   logic [DW-1:0]    w_shadow_n;
   logic [7:0]       w_char_n;
   logic             w_valid_n;
   logic [IDX_W-1:0] w_index_n;
   logic             w_done_n;
   logic             w_pending_n;

   assign w_src = show_new_time ? key : (show_alarm ? alarm_time : current_time);
   // The shadow shifts left per transfer, so the next character is always its top nibble.
   assign w_shadow_shl = r_shadow << 4;
   assign w_xfer       = r_valid && lcd_ready;
   assign w_last       = (r_index == LAST_IDX);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE: if (refresh) w_state_next = LOAD;
         LOAD: w_state_next = SEND;
         SEND: if (w_xfer && w_last) w_state_next = DONE;
         DONE: w_state_next = (r_pending || refresh) ? LOAD : IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      w_shadow_n  = r_shadow;
      w_char_n    = r_char;
      w_valid_n   = r_valid;
      w_index_n   = r_index;
      w_done_n    = 1'b0;
      w_pending_n = r_pending || (refresh && (r_state != IDLE));
      unique case (r_state)
         LOAD: begin
            w_shadow_n = w_src;
            w_char_n   = bcd_to_lcd(w_src[DW-1 -: 4]);
            w_index_n  = '0;
            w_valid_n  = 1'b1;
         end
         SEND: begin
            if (w_xfer) begin
               if (w_last) begin
                  w_valid_n = 1'b0;
                  w_done_n  = 1'b1;
               end else begin
                  w_shadow_n = w_shadow_shl;
                  w_char_n   = bcd_to_lcd(w_shadow_shl[DW-1 -: 4]);
                  w_index_n  = r_index + IDX_W'(1);
               end
            end
         end
         DONE:    w_pending_n = 1'b0;
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_shadow  <= '0;
         r_char    <= LCD_ZERO;
         r_valid   <= 1'b0;
         r_index   <= '0;
         r_done    <= 1'b0;
         r_pending <= 1'b0;
      end else begin
         r_shadow  <= w_shadow_n;
         r_char    <= w_char_n;
         r_valid   <= w_valid_n;
         r_index   <= w_index_n;
         r_done    <= w_done_n;
         r_pending <= w_pending_n;
      end
   end

   assign lcd_char   = r_char;
   assign lcd_valid  = r_valid;
   assign lcd_index  = r_index;
   assign frame_done = r_done;

   alarm_sounder #(
      .DW           (DW),
      .ALARM_CYCLES (ALARM_CYCLES)
   ) u_alarm (
      .clock        (clock),
      .reset        (reset),
      .alarm_time   (alarm_time),
      .current_time (current_time),
      .alarm_enable (alarm_enable),
      .alarm_button (alarm_button),
      .sound_alarm  (sound_alarm)
   );

endmodule

// File: tb/tb_lcd_frame_driver.sv
// Bench for lcd_frame_driver: transaction-level reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_lcd_frame_driver;

   localparam int N  = 4;
   localparam int AC = 5;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] alarm_time = 16'h0000;
   logic [15:0] current_time = 16'h1234;
   logic [15:0] key = 16'h0000;
   logic        show_new_time = 1'b0;
   logic        show_alarm = 1'b0;
   logic        alarm_enable = 1'b0;
   logic        alarm_button = 1'b0;
   logic        refresh = 1'b0;
   logic        lcd_ready = 1'b1;
   logic [7:0]  lcd_char;
   logic        lcd_valid;
   logic [1:0]  lcd_index;
   logic        frame_done;
   logic        sound_alarm;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   lcd_frame_driver #(.NUM_DIGITS(N), .ALARM_CYCLES(AC)) dut (
      .clock         (clock),
      .reset         (reset),
      .alarm_time    (alarm_time),
      .current_time  (current_time),
      .key           (key),
      .show_new_time (show_new_time),
      .show_alarm    (show_alarm),
      .alarm_enable  (alarm_enable),
      .alarm_button  (alarm_button),
      .refresh       (refresh),
      .lcd_char      (lcd_char),
      .lcd_valid     (lcd_valid),
      .lcd_ready     (lcd_ready),
      .lcd_index     (lcd_index),
      .frame_done    (frame_done),
      .sound_alarm   (sound_alarm)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // m_pos: -1 idle, 0 snapshot pending, 1..N sending character m_pos-1, N+1 done pulse
   int          m_pos = -1;
   bit          m_pend = 0;
   logic [15:0] m_snap = '0;
   logic [7:0]  m_char = 8'h30;
   int          m_idx = 0;
   bit          m_prev = 0;
   int          m_rem = 0;

   function automatic logic [7:0] ascii_of(input logic [15:0] v, input int k);
      int d;
      d = (v >> (4 * k)) & 16'hF;
      return (d < 10) ? 8'(48 + d) : 8'h3A;
   endfunction

   always @(posedge clock or negedge reset) begin
      bit match;
      if (!reset) begin
         m_pos = -1; m_pend = 0; m_snap = '0; m_char = 8'h30; m_idx = 0;
         m_prev = 0; m_rem = 0;
      end else begin
         if (m_pos == -1) begin
            if (refresh) m_pos = 0;
         end else if (m_pos == 0) begin
            m_snap = show_new_time ? key : (show_alarm ? alarm_time : current_time);
            if (refresh) m_pend = 1;
            m_pos = 1;
         end else if (m_pos <= N) begin
            if (refresh) m_pend = 1;
            if (lcd_ready) m_pos++;
         end else begin
            m_pos  = (m_pend || refresh) ? 0 : -1;
            m_pend = 0;
         end
         if (m_pos >= 1 && m_pos <= N) begin
            m_idx  = m_pos - 1;
            m_char = ascii_of(m_snap, N - m_pos);
         end
         match = alarm_enable && (current_time == alarm_time);
         if (alarm_button)         m_rem = 0;
         else if (match && !m_prev) m_rem = AC;
         else if (m_rem > 0)        m_rem--;
         m_prev = match;
      end
   end

   // ---------------- per-cycle compare and transfer log ----------------
   logic [7:0] acc_q[$];
   int         done_cnt = 0;

   always @(negedge clock) begin
      if (reset) begin
         chk("lcd_valid",   lcd_valid,   (m_pos >= 1 && m_pos <= N));
         chk("lcd_char",    lcd_char,    m_char);
         chk("lcd_index",   lcd_index,   m_idx);
         chk("frame_done",  frame_done,  (m_pos == N + 1));
         chk("sound_alarm", sound_alarm, (m_rem > 0));
         if (lcd_valid && lcd_ready) acc_q.push_back(lcd_char);
         if (frame_done) done_cnt++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_done(input string nm);
      int n;
      n = 0;
      while (frame_done !== 1'b1 && n < 200) begin tick(); n++; end
      chk(nm, (n < 200), 1);
   endtask

   task automatic check_acc(input string nm, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
      logic [7:0] e [4];
      e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
      chk({nm, "_count"}, acc_q.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < acc_q.size()) chk({nm, "_char"}, acc_q[i], e[i]);
   endtask

   function automatic int count_high_dummy();
      return 0;
   endfunction

   initial begin
      int n;
      int hi;
      int d0;

      // Reset state
      repeat (3) tick();
      chk("rst_char",  lcd_char,    8'h30);
      chk("rst_valid", lcd_valid,   1'b0);
      chk("rst_index", lcd_index,   2'd0);
      chk("rst_done",  frame_done,  1'b0);
      chk("rst_sound", sound_alarm, 1'b0);
      reset = 1'b1;
      repeat (2) tick();

      // Frame of current_time, back-to-back transfers
      acc_q.delete();
      current_time = 16'h1234;
      refresh = 1'b1;
      tick();
      refresh = 1'b0;
      chk("t1_valid_load", lcd_valid, 1'b0);
      tick();
      chk("t1_valid0", lcd_valid, 1'b1);
      chk("t1_char0",  lcd_char,  8'h31);
      chk("t1_idx0",   lcd_index, 2'd0);
      tick();
      chk("t1_char1", lcd_char, 8'h32);
      chk("t1_idx1",  lcd_index, 2'd1);
      tick();
      chk("t1_char2", lcd_char, 8'h33);
      tick();
      chk("t1_char3", lcd_char, 8'h34);
      chk("t1_idx3",  lcd_index, 2'd3);
      tick();
      chk("t1_done",   frame_done, 1'b1);
      chk("t1_valid_end", lcd_valid, 1'b0);
      tick();
      chk("t1_done_pulse", frame_done, 1'b0);
      check_acc("t1", 8'h31, 8'h32, 8'h33, 8'h34);

      // Backpressure and snapshot of alarm_time
      acc_q.delete();
      show_alarm = 1'b1;
      alarm_time = 16'h0959;
      refresh = 1'b1;
      tick();
      refresh = 1'b0;
      tick();
      chk("t2_char0", lcd_char, 8'h30);
      tick();
      lcd_ready = 1'b0;
      chk("t2_char1", lcd_char, 8'h39);
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i == 0) alarm_time = 16'h1111;
         chk("t2_stall_char", lcd_char, 8'h39);
         chk("t2_stall_idx",  lcd_index, 2'd1);
      end
      lcd_ready = 1'b1;
      wait_done("t2_timeout");
      check_acc("t2", 8'h30, 8'h39, 8'h35, 8'h39);
      tick();

      // Priority of key entry and error decode
      acc_q.delete();
      show_new_time = 1'b1;
      key = 16'hA0F7;
      refresh = 1'b1;
      tick();
      refresh = 1'b0;
      wait_done("t3_timeout");
      check_acc("t3", 8'h3A, 8'h30, 8'h3A, 8'h37);
      show_new_time = 1'b0;
      show_alarm = 1'b0;
      tick();

      // Pending refresh collapses into exactly one extra frame
      acc_q.delete();
      d0 = done_cnt;
      refresh = 1'b1;
      tick();
      refresh = 1'b0;
      n = 0;
      while (!(lcd_valid && lcd_index == 2'd2) && n < 50) begin tick(); n++; end
      chk("t4_reach_idx2", (n < 50), 1);
      refresh = 1'b1;
      tick();
      tick();
      refresh = 1'b0;
      repeat (30) tick();
      chk("t4_done_pulses", done_cnt - d0, 2);
      chk("t4_chars", acc_q.size(), 8);

      // Alarm timeout, no retrigger on a held match
      alarm_time = 16'h0700;
      current_time = 16'h0659;
      alarm_enable = 1'b1;
      repeat (2) tick();
      current_time = 16'h0700;
      hi = 0;
      for (int i = 0; i < 20; i++) begin tick(); if (sound_alarm) hi++; end
      chk("t5_alarm_len", hi, AC);

      // Silence while sounding
      current_time = 16'h0701;
      repeat (2) tick();
      current_time = 16'h0700;
      tick();
      chk("t6_sounding", sound_alarm, 1'b1);
      tick();
      alarm_button = 1'b1;
      tick();
      alarm_button = 1'b0;
      chk("t6_silenced", sound_alarm, 1'b0);
      hi = 0;
      for (int i = 0; i < 8; i++) begin tick(); if (sound_alarm) hi++; end
      chk("t6_no_retrigger", hi, 0);

      // Button coincident with a match edge
      current_time = 16'h0701;
      repeat (2) tick();
      current_time = 16'h0700;
      alarm_button = 1'b1;
      tick();
      alarm_button = 1'b0;
      hi = 0;
      for (int i = 0; i < 10; i++) begin if (sound_alarm) hi++; tick(); end
      chk("t6_button_wins", hi, 0);

      // Randomized traffic against the model
      for (int c = 0; c < 600; c++) begin
         refresh       = ($urandom_range(0, 7) == 0);
         lcd_ready     = ($urandom_range(0, 3) != 0);
         show_new_time = 1'($urandom_range(0, 1));
         show_alarm    = 1'($urandom_range(0, 1));
         alarm_enable  = ($urandom_range(0, 7) != 0);
         alarm_button  = ($urandom_range(0, 15) == 0);
         key           = 16'($urandom);
         if ($urandom_range(0, 9) == 0) current_time = 16'($urandom_range(0, 2));
         if ($urandom_range(0, 9) == 0) alarm_time   = 16'($urandom_range(0, 2));
         tick();
      end
      refresh = 1'b0;
      lcd_ready = 1'b1;
      alarm_button = 1'b0;
      alarm_enable = 1'b0;
      show_new_time = 1'b0;
      show_alarm = 1'b0;
      repeat (40) tick();

      // Asynchronous reset mid-SEND while sounding
      alarm_enable = 1'b1;
      alarm_time = 16'h0700;
      current_time = 16'h0701;
      repeat (2) tick();
      lcd_ready = 1'b0;
      current_time = 16'h0700;
      refresh = 1'b1;
      tick();
      refresh = 1'b0;
      tick();
      chk("t8_pre_valid", lcd_valid, 1'b1);
      chk("t8_pre_sound", sound_alarm, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      chk("t8_async_valid", lcd_valid, 1'b0);
      chk("t8_async_sound", sound_alarm, 1'b0);
      chk("t8_async_char",  lcd_char, 8'h30);
      chk("t8_async_idx",   lcd_index, 2'd0);
      tick();
      reset = 1'b1;
      lcd_ready = 1'b1;
      repeat (5) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
